// File: rtl/stopwatch_input_cond.sv
// stopwatch_input_cond: front-panel input conditioner for the stopwatch.
// Synchronizes the raw R/P pushbuttons and sel/load slide switches into d_clk and debounces them.
// It produces single-cycle press pulses for R and P, and registered, debounced sel/load values
// with a one-cycle sel_chg strobe.
//
// Ports:
//   d_clk        controller/display clock (only clock)
//   rst_n        asynchronous active-low reset
//   btn_r_raw    raw R (clear) pushbutton, active high, asynchronous
//   btn_p_raw    raw P (start/pause) pushbutton, active high, asynchronous
//   sw_sel_raw   raw mode switches
//   sw_load_raw  raw BCD preload switches ([7:4] tens, [3:0] units)
//   R, P         one-cycle debounced press pulses (R has priority over P)
//   sel, load    debounced, registered switch values
//   sel_chg      one-cycle pulse in the first cycle sel shows a new value
module stopwatch_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       d_clk,
    input  logic       rst_n,
    input  logic       btn_r_raw,
    input  logic       btn_p_raw,
    input  logic [1:0] sw_sel_raw,
    input  logic [7:0] sw_load_raw,
    output logic       R,
    output logic       P,
    output logic [1:0] sel,
    output logic [7:0] load,
    output logic       sel_chg
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } btn_state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for all 12 raw inputs: {R, P, sel[1:0], load[7:0]}
    // ------------------------------------------------------------------
    logic [11:0] raw_all;
    logic [11:0] sync1_q, sync2_q;

    assign raw_all = {btn_r_raw, btn_p_raw, sw_sel_raw, sw_load_raw};

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_all;
            sync2_q <= sync1_q;
        end
    end

    logic       btn_s [2];   // index 0 = R, 1 = P
    logic [9:0] sw_s;

    assign btn_s[0] = sync2_q[11];
    assign btn_s[1] = sync2_q[10];
    assign sw_s     = sync2_q[9:0];

    // ------------------------------------------------------------------
    // Button debounce FSMs
    // ------------------------------------------------------------------
    btn_state_e       state_q [2];
    btn_state_e       state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic             fire    [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            fire[i]    = 1'b0;
            case (state_q[i])
                StReleased: begin
                    if (btn_s[i]) begin
                        state_d[i] = StPressWait;
                        cnt_d[i]   = '0;
                    end
                end
                StPressWait: begin
                    if (!btn_s[i]) begin
                        state_d[i] = StReleased;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StPressed;
                        fire[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StPressed: begin
                    if (!btn_s[i]) begin
                        state_d[i] = StReleaseWait;
                        cnt_d[i]   = '0;
                    end
                end
                StReleaseWait: begin
                    if (btn_s[i]) begin
                        // Bounce on release: back to held, no new pulse.
                        state_d[i] = StPressed;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StReleased;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StReleased;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StReleased;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // R is "held" in the cycle the pulse would be visible. Using the next state also covers
    // a simultaneous R/P debounce, since R then enters StPressed on the same edge.
    logic r_hold_d;
    logic r_pulse_q, p_pulse_q;

    assign r_hold_d = (state_d[0] == StPressed) || (state_d[0] == StReleaseWait);

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_q <= 1'b0;
            p_pulse_q <= 1'b0;
        end else begin
            r_pulse_q <= fire[0];
            p_pulse_q <= fire[1] && !r_hold_d;
        end
    end

    assign R = r_pulse_q;
    assign P = p_pulse_q;

    // ------------------------------------------------------------------
    // Switch group: shared candidate and stability counter for all 10 bits
    // ------------------------------------------------------------------
    logic [9:0]       cand_q, cand_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       load_q, load_d;
    logic             sel_chg_q, sel_chg_d;

    always_comb begin
        cand_d    = cand_q;
        sw_cnt_d  = sw_cnt_q;
        sel_d     = sel_q;
        load_d    = load_q;
        sel_chg_d = 1'b0;
        if (sw_s != cand_q) begin
            cand_d   = sw_s;
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CntMax) begin
            // Counter holds at max, so a stable group is re-copied every cycle (no-op).
            sel_d     = cand_q[9:8];
            load_d    = cand_q[7:0];
            sel_chg_d = (cand_q[9:8] != sel_q);
        end else begin
            sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q    <= '0;
            sw_cnt_q  <= '0;
            sel_q     <= '0;
            load_q    <= '0;
            sel_chg_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            sw_cnt_q  <= sw_cnt_d;
            sel_q     <= sel_d;
            load_q    <= load_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel     = sel_q;
    assign load    = load_q;
    assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_stopwatch_input_cond.sv
// Bench for stopwatch_input_cond: directed front-panel scenarios followed by random stimulus.
// A reference model predicts every cycle's outputs into a queue; a monitor compares on negedge.
// The model works on run lengths of synchronized samples: a debounced level flips after
// D+1 consecutive opposite samples, and the switch group is published after D+1 equal samples.
module tb_stopwatch_input_cond;

    localparam int unsigned D = 8;

    logic       d_clk;
    logic       rst_n;
    logic       btn_r_raw;
    logic       btn_p_raw;
    logic [1:0] sw_sel_raw;
    logic [7:0] sw_load_raw;
    logic       R;
    logic       P;
    logic [1:0] sel;
    logic [7:0] load;
    logic       sel_chg;

    stopwatch_input_cond #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .d_clk      (d_clk),
        .rst_n      (rst_n),
        .btn_r_raw  (btn_r_raw),
        .btn_p_raw  (btn_p_raw),
        .sw_sel_raw (sw_sel_raw),
        .sw_load_raw(sw_load_raw),
        .R          (R),
        .P          (P),
        .sel        (sel),
        .load       (load),
        .sel_chg    (sel_chg)
    );

    initial d_clk = 1'b0;
    always #5 d_clk = ~d_clk;

    typedef struct packed {
        logic       r;
        logic       p;
        logic [1:0] sel;
        logic [7:0] load;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- reference model state ----------------
    logic [11:0] m_d1, m_d2;     // two-sample input delay
    logic        m_deb [2];      // debounced button level (0 = R, 1 = P)
    int          m_run [2];      // consecutive samples disagreeing with m_deb
    logic [9:0]  m_last;         // last synchronized switch group
    int          m_swrun;        // consecutive samples equal to m_last
    logic [1:0]  m_sel;
    logic [7:0]  m_load;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic model_reset();
        m_d1    = '0;
        m_d2    = '0;
        m_deb[0] = 1'b0;
        m_deb[1] = 1'b0;
        m_run[0] = 0;
        m_run[1] = 0;
        m_last  = '0;
        m_swrun = 1;
        m_sel   = '0;
        m_load  = '0;
    endtask

    // Called right after each rising edge, before inputs change; predicts outputs for this cycle.
    task automatic model_step();
        exp_t        e;
        logic [11:0] s;
        logic        rose [2];
        logic        si;
        logic        prev;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(zero_exp());
            return;
        end
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = {btn_r_raw, btn_p_raw, sw_sel_raw, sw_load_raw};
        for (int i = 0; i < 2; i++) begin
            si   = (i == 0) ? s[11] : s[10];
            prev = m_deb[i];
            if (si != m_deb[i]) m_run[i] = m_run[i] + 1;
            else                m_run[i] = 0;
            if (m_run[i] == int'(D) + 1) begin
                m_deb[i] = si;
                m_run[i] = 0;
            end
            rose[i] = !prev && m_deb[i];
        end
        e     = '0;
        e.r   = rose[0];
        e.p   = rose[1] && !m_deb[0];
        if (s[9:0] == m_last) begin
            if (m_swrun < int'(D) + 1) m_swrun = m_swrun + 1;
        end else begin
            m_last  = s[9:0];
            m_swrun = 1;
        end
        if (m_swrun >= int'(D) + 1) begin
            e.chg  = (m_last[9:8] != m_sel);
            m_sel  = m_last[9:8];
            m_load = m_last[7:0];
        end
        e.sel  = m_sel;
        e.load = m_load;
        exp_q.push_back(e);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge d_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("R",       {7'd0, R},       {7'd0, e.r});
                check("P",       {7'd0, P},       {7'd0, e.p});
                check("sel",     {6'd0, sel},     {6'd0, e.sel});
                check("load",    load,            e.load);
                check("sel_chg", {7'd0, sel_chg}, {7'd0, e.chg});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge d_clk);
            model_step();
            #2;
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must already be zero at this cycle's negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = zero_exp();
    endtask

    initial begin : stim
        int         tog;
        int         k;
        logic [9:0] v;
        rst_n       = 1'b0;
        btn_r_raw   = 1'b0;
        btn_p_raw   = 1'b0;
        sw_sel_raw  = 2'b00;
        sw_load_raw = 8'h00;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Clean R press, long hold, release, re-press.
        btn_r_raw = 1'b1; tick(100);
        btn_r_raw = 1'b0; tick(20);
        btn_r_raw = 1'b1; tick(30);
        btn_r_raw = 1'b0; tick(20);

        // Bouncy P press, then a short glitch while held.
        btn_p_raw = 1'b1; tick(5);
        btn_p_raw = 1'b0; tick(1);
        btn_p_raw = 1'b1; tick(5);
        btn_p_raw = 1'b0; tick(2);
        btn_p_raw = 1'b1; tick(20);
        btn_p_raw = 1'b0; tick(3);
        btn_p_raw = 1'b1; tick(20);
        btn_p_raw = 1'b0; tick(20);

        // Simultaneous press, then P pressed while R held.
        btn_r_raw = 1'b1; btn_p_raw = 1'b1; tick(30);
        btn_r_raw = 1'b0; btn_p_raw = 1'b0; tick(20);
        btn_r_raw = 1'b1; tick(15);
        btn_p_raw = 1'b1; tick(30);
        btn_r_raw = 1'b0; btn_p_raw = 1'b0; tick(20);

        // Switch chatter on sel, then load-only changes including non-BCD digits.
        sw_sel_raw = 2'b10; tick(3);
        sw_sel_raw = 2'b00; tick(4);
        sw_sel_raw = 2'b10; tick(20);
        sw_load_raw = 8'h45; tick(20);
        sw_load_raw = 8'hAF; tick(20);

        // Reset mid-debounce, then mid-pulse, then release with P already held.
        btn_p_raw = 1'b1; tick(5);
        do_reset(); tick(2);
        btn_p_raw = 1'b0; rst_n = 1'b1; tick(5);
        btn_r_raw = 1'b1; tick(11);
        do_reset(); btn_r_raw = 1'b0; btn_p_raw = 1'b1; tick(3);
        rst_n = 1'b1; tick(30);
        btn_p_raw = 1'b0; tick(20);

        // Random phase with varying bounce rates and occasional resets.
        tog = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) tog = int'($urandom_range(3, 30));
            tick(1);
            if ($urandom_range(0, tog - 1) == 0) btn_r_raw = ~btn_r_raw;
            if ($urandom_range(0, tog - 1) == 0) btn_p_raw = ~btn_p_raw;
            if ($urandom_range(0, 24) == 0) begin
                k = int'($urandom_range(0, 9));
                v = {sw_sel_raw, sw_load_raw};
                v[k] = ~v[k];
                {sw_sel_raw, sw_load_raw} = v;
            end
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
                tick(2);
                rst_n = 1'b1;
            end
        end

        @(negedge d_clk);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
